// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, drives the word-aligned
//   byte address into a combinational instruction memory, captures each
//   returned instruction together with its PC in a small FIFO and presents the
//   FIFO head to decode over a valid/ready handshake. Branch redirects from
//   execute flush the FIFO and reload the PC.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   imem_addr    out  byte address to instruction memory (the PC)
//   imem_rd      in   instruction returned combinationally for imem_addr
//   redirect     in   single-cycle branch-taken pulse
//   redirect_pc  in   branch target byte address (low two bits ignored)
//   instr_valid  out  FIFO head holds a valid instruction
//   instr_ready  in   decode accepts the head this cycle
//   instr        out  head instruction, 0 when not valid
//   instr_pc     out  byte address of the head instruction, 0 when not valid
//   fetch_fault  out  sticky: PC left the valid memory range
module fetch_unit #(
  parameter int unsigned              ADDR_W    = 24,
  parameter int unsigned              INSTR_W   = 24,
  parameter logic [ADDR_W-1:0]        RESET_PC  = '0,
  parameter int unsigned              MEM_WORDS = 140,
  parameter int unsigned              DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] MEM_WORDS_C = ADDR_W'(MEM_WORDS);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              fault_q, fault_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              pop;
  logic              push;
  logic              in_range;
  logic [ENT_W-1:0]  head;

  always_comb begin
    pop      = (count_q != '0) & instr_ready;
    in_range = ({2'b00, pc_q[ADDR_W-1:2]} < MEM_WORDS_C);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    push     = !redirect & in_range & ((count_q < DEPTH_C) | pop);

    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fault_d  = fault_q;

    if (redirect) begin
      // The head popped this cycle was consumed by decode; everything else goes.
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fault_d  = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + ADDR_W'(4);
      end
      if (!in_range) begin
        fault_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fault_q  <= fault_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {imem_rd, pc_q};
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? head[ENT_W-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0]     : '0;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] imem_addr;
  logic [23:0] imem_rd;
  logic        redirect;
  logic [23:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [23:0] instr_pc;
  logic        fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: FIFO contents as a queue of {instr, pc}, plus PC and fault.
  logic [47:0] mq[$];
  logic [23:0] mpc;
  bit          mfault;
  bit          known = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds k+100.
  assign imem_rd = {4'b0, imem_addr[21:2]} + 24'd100;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fetch_fault (fetch_fault)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit rdy, input bit rd, input logic [23:0] rpc);
    bit popped;
    if (r) begin
      mq.delete();
      mpc    = 24'h0;
      mfault = 0;
      return;
    end
    popped = (mq.size() != 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (rd) begin
      mq.delete();
      mpc    = {rpc[23:2], 2'b00};
      mfault = 0;
    end else if (mpc[23:2] >= 22'd140) begin
      mfault = 1;
    end else if (mq.size() < 2) begin
      mq.push_back({{4'b0, mpc[21:2]} + 24'd100, mpc});
      mpc = mpc + 24'd4;
    end
  endtask

  // One clock: drive inputs, check outputs on the falling edge, then advance the model.
  task automatic tick(input bit r, input bit rdy, input bit rd, input logic [23:0] rpc);
    reset       = r;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    if (known) begin
      chk("imem_addr",   imem_addr, mpc);
      chk("fetch_fault", {23'b0, fetch_fault}, {23'b0, mfault});
      chk("instr_valid", {23'b0, instr_valid}, {23'b0, mq.size() != 0});
      chk("instr",       instr,    (mq.size() != 0) ? mq[0][47:24] : 24'h0);
      chk("instr_pc",    instr_pc, (mq.size() != 0) ? mq[0][23:0]  : 24'h0);
    end
    @(posedge clk);
    model_edge(r, rdy, rd, rpc);
    if (r) known = 1;
    #1;
  endtask

  initial begin
    reset = 1; instr_ready = 0; redirect = 0; redirect_pc = 0;
    #1;
    // Reset, with a redirect in the same cycle as reset; redirect must be ignored.
    tick(1, 0, 1, 24'h000040);
    tick(1, 1, 1, 24'h000080);
    // Streaming with ready held high.
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
    // Stall for 5 cycles after reset, then release.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("stall_pc", imem_addr, 24'd8);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    // Redirect to a misaligned target while the FIFO holds pc 4 and 8.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 24'h000023);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    // Run off the end of memory, drain, then recover with a redirect to 0.
    tick(0, 1, 1, 24'd552);
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
    chk("fault_pc", imem_addr, 24'd560);
    tick(0, 1, 1, 24'h0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    // Alternating ready.
    for (int i = 0; i < 20; i++) tick(0, i[0] == 1'b0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit          r, rdy, rd;
      logic [23:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = 24'($urandom_range(0, 150 * 4 + 3));
      tick(r, rdy, rd, rpc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the processor. Owns the program counter and drives the word-aligned byte address into the combinational instruction memory (24-bit address in, 24-bit instruction out, same cycle).
- Captures each returned instruction together with its PC into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Takes branch redirects from execute, which flush the FIFO and reload the PC.

Parameters:
- ADDR_W, 24, PC and memory address width in bits.
- INSTR_W, 24, instruction width in bits.
- RESET_PC, 24'h000000, PC value loaded on reset.
- MEM_WORDS, 140, number of valid instruction words; a fetch at word index >= MEM_WORDS is a fault.
- DEPTH, 2, FIFO entries; must be a power of two and >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc.
- imem_rd  in  INSTR_W  instruction returned combinationally for imem_addr.
- redirect  in  1  single-cycle branch-taken pulse from execute.
- redirect_pc  in  ADDR_W  branch target byte address.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  INSTR_W  head instruction; 0 when not valid.
- instr_pc  out  ADDR_W  byte address of the head instruction; 0 when not valid.
- fetch_fault  out  1  sticky flag: PC left the valid memory range.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset (sampled on clk while reset=1):
  - pc <= RESET_PC; count, rd_ptr and wr_ptr <= 0; fetch_fault <= 0.
  - Outputs then read instr_valid=0, instr=0, instr_pc=0.
  - Reset mid-operation discards all FIFO contents and any pending redirect.
- Address path: imem_addr = pc, combinational from the pc register. The instruction memory indexes by addr[21:2], so pc[1:0] is always 00.
- Definitions:
  - pop = instr_valid & instr_ready.
  - in_range = (pc[ADDR_W-1:2] < MEM_WORDS).
  - push = !redirect & in_range & ((count < DEPTH) | pop).
- On push:
  - mem[wr_ptr] <= {imem_rd, pc}; wr_ptr increments.
  - pc <= pc + 4, wrapping modulo 2^ADDR_W.
- On pop: rd_ptr increments.
- count update:
  - count <= count + push - pop; simultaneous push and pop leaves count unchanged.
  - Full plus pop allows a push in the same cycle (no bubble).
- Redirect has priority over everything except reset:
  - The pop of the current head is still honoured; decode consumed it.
  - count, rd_ptr and wr_ptr <= 0; no push that cycle.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned targets are truncated silently.
  - fetch_fault <= 0.
- Range fault:
  - While !in_range and no redirect: no push, pc holds, fetch_fault <= 1.
  - fetch_fault stays at 1 until reset or a redirect.
  - The FIFO continues to drain normally.
- Outputs:
  - instr_valid = (count != 0).
  - instr and instr_pc come from mem[rd_ptr], gated to 0 when count == 0.
- Latency:
  - First cycle after reset deasserts: fetch of RESET_PC; instr_valid=1 on the following cycle.
  - Redirect sampled at cycle N: target fetched at N+1, instr_valid with instr_pc = target at N+2.
- Throughput: one instruction per cycle when instr_ready is held at 1.
- Stall: with instr_ready=0 the FIFO fills to DEPTH, then pc holds and imem_addr is stable.
- Wrap-around: pc = 24'hFFFFFC increments to 24'h000000. This case can only occur with MEM_WORDS forced larger.
- count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset, then instr_ready=1 with memory word k = k+100:
  - valid rises one cycle after reset drops.
  - Stream is instr = 100, 101, 102… with instr_pc = 0, 4, 8… and no gaps.
- instr_ready=0 for 5 cycles after reset:
  - count saturates at 2; pc = 8 and holds; head stays instr_pc=0.
  - Raising ready yields pc 0, 4, 8 back-to-back.
- Redirect pulse with redirect_pc=24'h000023 while FIFO holds pc 4 and 8 and ready=1:
  - Head pc 4 is accepted; FIFO flushes.
  - Two cycles later instr_pc=24'h000020, then 24'h000024.
- redirect asserted in the same cycle as reset:
  - After reset, fetch starts at RESET_PC; redirect is ignored.
- redirect_pc=4*138 (MEM_WORDS=140), ready=1:
  - Words 138 and 139 delivered; pc holds at 560; fetch_fault=1; instr_valid drops after drain.
  - A redirect to 0 clears fetch_fault and restarts the stream at 0.
- Alternating instr_ready 1/0 for 20 cycles:
  - Delivered instr_pc sequence is strictly +4 with no duplicates or drops.
  - count never exceeds 2.
